sha256_round_engine: RTL
========================

# sha256_round_engine

Sequential SHA-256 compression core: consumes the 64-word message schedule W0..W63, one word per accepted beat, and applies the 64 compression rounds to an incoming 256-bit chaining value. It sits downstream of the message-schedule expansion (w0..w15 → w16..w63) and turns schedule words into the updated hash state for one 512-bit block. The datapath is one round per cycle, with a valid/ready input stream so the schedule source may stall.

## Interface
Parameters:
- none. SHA-256 is fixed; all widths are constants.

Ports:
- `i_clk`  in  1  single clock; all state changes on the rising edge.
- `i_rst_n`  in  1  synchronous, active-low reset.
- `i_start`  in  1  starts one block; accepted only in IDLE.
- `i_h_in`  in  256  chaining value; [255:224]=H0 (a) … [31:0]=H7 (h); sampled on the accepted start.
- `i_w_valid`  in  1  schedule word present.
- `i_w_data`  in  32  schedule word W_t, with t in arrival order 0..63.
- `o_w_ready`  out  1  engine can accept a word this cycle.
- `o_busy`  out  1  high from accepted start until `o_done`.
- `o_done`  out  1  one-cycle pulse when the digest is valid.
- `o_digest`  out  256  H_in + final a..h, per word mod 2^32; same packing as `i_h_in`.

## Operation
- FSM states: IDLE → ROUND → FINAL → DONE → IDLE.
- IDLE, `i_start`=1:
  - a..h ← `i_h_in`, and `i_h_in` is copied to the `h_save` register.
  - Round counter t ← 0.
  - Next state is ROUND.
- ROUND:
  - `o_w_ready`=1.
  - On each beat with `i_w_valid`·`o_w_ready`, perform round t:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W_t
    - T2 = Σ0(a) + Maj(a,b,c)
    - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2
    - t←t+1
  - All additions are 32-bit with the carry discarded.
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
  - No beat in a cycle: all state holds. Stalls of any length are legal.
  - The beat at t=63 moves the FSM to FINAL.
- FINAL:
  - `o_digest`[i] ← `h_save`[i] + reg[i] for each of the 8 words.
  - `o_w_ready`=0.
  - Next state is DONE.
- DONE:
  - `o_done`=1 for exactly this cycle.
  - Next state is IDLE.
- `o_digest` holds its value until the next FINAL or a reset.
- `i_start` outside IDLE is ignored; no queuing.
- `i_w_valid` outside ROUND is ignored; no word is consumed.
- Reset:
  - `i_rst_n`=0 on any edge forces IDLE, t=0, a..h=0, `h_save`=0, `o_digest`=0, `o_done`=0, `o_busy`=0, `o_w_ready`=0.
  - An in-flight block is discarded.
- Multi-block messages: the user feeds `o_digest` back into `i_h_in` on the next start.

## Timing
- Start edge: `o_busy`=1 and `o_w_ready`=1 from the next cycle.
- No stalls: 64 beats in cycles 1..64 after start, FINAL in cycle 65, `o_done` in cycle 66. Start to done is 66 cycles.
- Each stall cycle adds exactly one cycle.
- `o_busy` falls together with the IDLE return; it is low in the cycle after `o_done`.
- Back-to-back blocks: `i_start` may be asserted in the cycle after `o_done`.
- `o_w_ready` is a registered state decode; it has no combinational path from `i_w_valid`.
- K[t] is looked up combinationally from t in the same cycle as the beat.

## Structure
- Package `sha256_pkg`:
  - Types `word_t` (32 bit) and `state_t` (8×word_t).
  - The 64-entry K array.
  - The IV constant H0..H7 (6a09e667 … 5be0cd19).
  - Functions `rotr`, `big_sigma0`, `big_sigma1`, `ch`, `maj`. These are shared with the schedule expansion's small-sigma functions.
- Sub-module `sha256_round`: purely combinational, (state_t, K, W) → next state_t. It keeps the FSM/register file separate from the round logic and allows a future 2-round unroll.

## Test plan
- "abc" (W0=61626380, W1..W14=0, W15=00000018, W16..63 from the reference model), `i_h_in`=IV, no stalls → `o_done` at cycle 66, `o_digest`=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message (W0=80000000, the rest of the padded block zero), IV → `o_digest`=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- "abc" with random `i_w_valid` gaps (≈40% idle) → same digest; done cycle = 66 + number of stall cycles; a..h unchanged on stall cycles.
- Two-block 56-byte "abcdbcdecdefdefg…nopq", with block 2 started the cycle after `o_done` using the fed-back digest → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- `i_start` pulsed mid-ROUND, and `i_w_valid` held high in IDLE/FINAL → no effect; the "abc" digest is unchanged.
- `i_rst_n`=0 at round 30, then "abc" restarted → all outputs 0 during reset; correct digest after 66 cycles.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and round functions for the schedule
// expansion and the compression engine.
package sha256_pkg;

    typedef logic [31:0] word_t;
    // Index 7 is 'a' / H0, index 0 is 'h' / H7, so this matches the 256-bit packing.
    typedef word_t [7:0] state_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL, ST_DONE} fsm_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam state_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 compression round, purely combinational, so the engine can
// later chain two of these per cycle.
module sha256_round
    import sha256_pkg::*;
(
    input  state_t s_in,
    input  word_t  k,
    input  word_t  w,
    output state_t s_out
);
    word_t a, b, c, d, e, f, g, h;
    word_t t1, t2;

    assign {a, b, c, d, e, f, g, h} = s_in;

    assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
    assign t2 = big_sigma0(a) + maj(a, b, c);

    assign s_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_round_engine.sv
// Sequential SHA-256 compression: one round per accepted schedule word,
// then a feed-forward add into the registered digest.
module sha256_round_engine
    import sha256_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [255:0] i_h_in,
    input  logic         i_w_valid,
    input  logic [31:0]  i_w_data,
    output logic         o_w_ready,
    output logic         o_busy,
    output logic         o_done,
    output logic [255:0] o_digest
);
    fsm_t       state, state_nxt;
    state_t     regs, regs_nxt, h_save, digest_q;
    logic [5:0] t;
    logic       beat;

    assign beat = (state == ST_ROUND) && i_w_valid;

    sha256_round u_round (
        .s_in  (regs),
        .k     (K[t]),
        .w     (i_w_data),
        .s_out (regs_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_start) state_nxt = ST_ROUND;
            ST_ROUND: if (beat && t == 6'd63) state_nxt = ST_FINAL;
            ST_FINAL: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            regs     <= '0;
            h_save   <= '0;
            digest_q <= '0;
            t        <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && i_start) begin
                regs   <= i_h_in;
                h_save <= i_h_in;
                t      <= '0;
            end
            // t wraps to 0 on the last beat, ready for the next block.
            if (beat) begin
                regs <= regs_nxt;
                t    <= t + 6'd1;
            end
            if (state == ST_FINAL) begin
                for (int i = 0; i < 8; i++)
                    digest_q[i] <= h_save[i] + regs[i];
            end
        end
    end

    // Outputs decode the registered state only; nothing combinational from i_w_valid.
    assign o_w_ready = (state == ST_ROUND);
    assign o_busy    = (state != ST_IDLE);
    assign o_done    = (state == ST_DONE);
    assign o_digest  = digest_q;

endmodule
